// File: rtl/uart_blk_pkg.sv
// Shared types and sizes for the uart <-> SM4 block controller.
// Provides the FSM state encoding, block width and byte-count width.
package uart_blk_pkg;

    typedef enum logic [2:0] {
        S_RX  = 3'd0,
        S_REQ = 3'd1,
        S_RES = 3'd2,
        S_TXL = 3'd3,
        S_TXW = 3'd4
    } state_t;

    localparam int BLK_W = 128;
    localparam int CNT_W = $clog2(BLK_W / 8);

endpackage

// File: rtl/uart_idle_timer.sv
// Idle timer for a partially received block.
// Ports: clk, rst (sync, active-high), en, clr in; expire pulse out.
module uart_idle_timer #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] tmr;

    // Held at zero whenever disabled, so each enable starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst || clr || !en) begin
            tmr <= '0;
        end else if (tmr == LAST) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + TW'(1);
        end
    end

    assign expire = en && !clr && (tmr == LAST);

endmodule

// File: rtl/uart_blk_ctrl.sv
// Packs received uart bytes into a 128-bit block for the SM4 core and
// streams the 128-bit result back out through uart tx, one block at a time.
// Ports: rx_pdvalid/rx_pdata in; tx_pdvalid/tx_pdata out, tx_done in;
// blk_valid/blk_data out, blk_ready in; res_valid/res_data in, res_ready out;
// busy, err_timeout, err_overrun status out. All outputs are registered.
module uart_blk_ctrl
    import uart_blk_pkg::*;
#(
    parameter int BLK_BYTES   = BLK_W / 8,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_pdvalid,
    input  logic [7:0]       rx_pdata,
    output logic             tx_pdvalid,
    output logic [7:0]       tx_pdata,
    input  logic             tx_done,
    output logic             blk_valid,
    output logic [BLK_W-1:0] blk_data,
    input  logic             blk_ready,
    input  logic             res_valid,
    input  logic [BLK_W-1:0] res_data,
    output logic             res_ready,
    output logic             busy,
    output logic             err_timeout,
    output logic             err_overrun
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_BYTES - 1);

    state_t           state;
    logic [CNT_W-1:0] rx_cnt;
    logic [CNT_W-1:0] tx_cnt;
    logic [BLK_W-1:0] shreg;
    logic             tmr_en;
    logic             expire;

    assign tmr_en = (state == S_RX) && (rx_cnt != '0);

    uart_idle_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_idle_timer (
        .clk   (clk),
        .rst   (rst),
        .en    (tmr_en),
        .clr   (rx_pdvalid),
        .expire(expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RX;
            rx_cnt      <= '0;
            tx_cnt      <= '0;
            shreg       <= '0;
            blk_data    <= '0;
            blk_valid   <= 1'b0;
            res_ready   <= 1'b0;
            tx_pdvalid  <= 1'b0;
            tx_pdata    <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            tx_pdvalid  <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= rx_pdvalid && (state != S_RX);
            unique case (state)
                S_RX: begin
                    // A byte in the expiry cycle takes priority over the timeout.
                    if (rx_pdvalid) begin
                        blk_data <= {blk_data[BLK_W-9:0], rx_pdata};
                        busy     <= 1'b1;
                        if (rx_cnt == CNT_LAST) begin
                            rx_cnt    <= '0;
                            blk_valid <= 1'b1;
                            state     <= S_REQ;
                        end else begin
                            rx_cnt <= rx_cnt + CNT_W'(1);
                        end
                    end else if (expire) begin
                        rx_cnt      <= '0;
                        blk_data    <= '0;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        res_ready <= 1'b1;
                        state     <= S_RES;
                    end
                end
                S_RES: begin
                    if (res_valid) begin
                        shreg     <= res_data;
                        res_ready <= 1'b0;
                        state     <= S_TXL;
                    end
                end
                S_TXL: begin
                    tx_pdata   <= shreg[BLK_W-1 -: 8];
                    tx_pdvalid <= 1'b1;
                    state      <= S_TXW;
                end
                S_TXW: begin
                    if (tx_done) begin
                        shreg <= {shreg[BLK_W-9:0], 8'h00};
                        if (tx_cnt == CNT_LAST) begin
                            tx_cnt <= '0;
                            busy   <= 1'b0;
                            state  <= S_RX;
                        end else begin
                            tx_cnt <= tx_cnt + CNT_W'(1);
                            state  <= S_TXL;
                        end
                    end
                end
                default: state <= S_RX;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_blk_ctrl.sv
// Self-checking bench for uart_blk_ctrl with a short idle timeout.
// Expected blocks and tx bytes are queued at stimulus time, compared on output.
module tb_uart_blk_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx_pdvalid;
    logic [7:0]   rx_pdata;
    logic         tx_pdvalid;
    logic [7:0]   tx_pdata;
    logic         tx_done;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic         blk_ready;
    logic         res_valid;
    logic [127:0] res_data;
    logic         res_ready;
    logic         busy;
    logic         err_timeout;
    logic         err_overrun;

    int checks = 0;
    int failures = 0;
    int n_tout = 0;
    int n_ovr = 0;
    int n_txv = 0;

    logic [127:0] blk_q[$];
    logic [7:0]   tx_q[$];
    logic [127:0] acc;
    int           acc_n;

    uart_blk_ctrl #(
        .BLK_BYTES  (16),
        .TIMEOUT_CYC(50)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_pdvalid (rx_pdvalid),
        .rx_pdata   (rx_pdata),
        .tx_pdvalid (tx_pdvalid),
        .tx_pdata   (tx_pdata),
        .tx_done    (tx_done),
        .blk_valid  (blk_valid),
        .blk_data   (blk_data),
        .blk_ready  (blk_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .busy       (busy),
        .err_timeout(err_timeout),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_tout <= n_tout + int'(err_timeout);
        n_ovr  <= n_ovr + int'(err_overrun);
        n_txv  <= n_txv + int'(tx_pdvalid);
    end

    task automatic drive_rx(input logic [7:0] b);
        rx_pdvalid = 1'b1;
        rx_pdata   = b;
        @(negedge clk);
        rx_pdvalid = 1'b0;
    endtask

    // Bytes sent while the controller is collecting; model packs them.
    task automatic send_bytes(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = base + 8'(i);
            acc = {acc[119:0], b};
            acc_n++;
            if (acc_n == 16) begin
                blk_q.push_back(acc);
                acc_n = 0;
            end
            drive_rx(b);
        end
    endtask

    task automatic check_block(input string tag);
        logic [127:0] e;
        e = blk_q.pop_front();
        checks++;
        if (blk_valid !== 1'b1 || blk_data !== e) begin
            failures++;
            $display("FAIL %s: valid=%b data=%h expected valid=1 data=%h",
                     tag, blk_valid, blk_data, e);
        end
    endtask

    task automatic do_handshake(input string tag);
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
        checks++;
        if (blk_valid !== 1'b0 || res_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s: blk_valid=%b res_ready=%b expected 0/1",
                     tag, blk_valid, res_ready);
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({tx_pdvalid, blk_valid, res_ready, busy, err_timeout,
             err_overrun} !== 6'b0 || blk_data !== '0 || tx_pdata !== '0) begin
            failures++;
            $display("FAIL reset_outputs: flags=%b blk=%h tx=%h expected 0",
                     {tx_pdvalid, blk_valid, res_ready, busy, err_timeout,
                      err_overrun}, blk_data, tx_pdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || blk_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b blk_valid=%b expected 0",
                     busy, blk_valid);
        end
    endtask

    task automatic test_block_pack;
        logic [127:0] held;
        bit ok;
        send_bytes(8'h00, 15);
        checks++;
        if (blk_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL blk_early: blk_valid=%b busy=%b expected 0/1",
                     blk_valid, busy);
        end
        send_bytes(8'h0F, 1);
        held = blk_data;
        check_block("blk_pack");
        checks++;
        if (held !== 128'h000102030405060708090A0B0C0D0E0F) begin
            failures++;
            $display("FAIL blk_const: got %h expected 000102..0F", held);
        end
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (blk_valid !== 1'b1 || blk_data !== held || res_ready !== 1'b0)
                ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL blk_hold: valid=%b data=%h expected 1/%h",
                     blk_valid, blk_data, held);
        end
        do_handshake("blk_hs");
    endtask

    task automatic test_tx_stream(input logic [127:0] res, input bit inject);
        bit ok_pulse, ok_hold, ok_gap;
        logic [7:0] cur;
        int txv0;
        for (int i = 0; i < 16; i++) tx_q.push_back(res[127 - 8*i -: 8]);
        txv0 = n_txv;
        res_data  = res;
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        checks++;
        if (res_ready !== 1'b0 || tx_pdvalid !== 1'b0) begin
            failures++;
            $display("FAIL res_hs: res_ready=%b tx_pdvalid=%b expected 0/0",
                     res_ready, tx_pdvalid);
        end
        @(negedge clk);
        checks++;
        if (tx_pdvalid !== 1'b1) begin
            failures++;
            $display("FAIL tx_first_lat: tx_pdvalid=%b expected 1", tx_pdvalid);
        end
        ok_pulse = 1'b1;
        ok_hold  = 1'b1;
        ok_gap   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cur = tx_q.pop_front();
            checks++;
            if (tx_pdata !== cur) begin
                failures++;
                $display("FAIL tx_byte%0d: got %h expected %h", i, tx_pdata, cur);
            end
            @(negedge clk);
            if (tx_pdvalid !== 1'b0) ok_pulse = 1'b0;
            if (inject && i == 5) begin
                drive_rx(8'hAA);
                checks++;
                if (err_overrun !== 1'b1) begin
                    failures++;
                    $display("FAIL ovr_txw: err_overrun=%b expected 1",
                             err_overrun);
                end
            end
            repeat (2) @(negedge clk);
            if (tx_pdata !== cur || tx_pdvalid !== 1'b0) ok_hold = 1'b0;
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            if (i < 15) begin
                if (tx_pdvalid !== 1'b0) ok_gap = 1'b0;
                @(negedge clk);
                if (tx_pdvalid !== 1'b1) ok_gap = 1'b0;
            end else begin
                checks++;
                if (busy !== 1'b0 || tx_pdvalid !== 1'b0) begin
                    failures++;
                    $display("FAIL tx_end: busy=%b tx_pdvalid=%b expected 0/0",
                             busy, tx_pdvalid);
                end
            end
        end
        checks++;
        if (!ok_pulse || !ok_hold || !ok_gap) begin
            failures++;
            $display("FAIL tx_timing: pulse=%b hold=%b gap=%b expected 111",
                     ok_pulse, ok_hold, ok_gap);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (n_txv - txv0 !== 16) begin
            failures++;
            $display("FAIL tx_count: got %0d expected 16", n_txv - txv0);
        end
    endtask

    task automatic test_timeout;
        bit early;
        send_bytes(8'h40, 5);
        early = 1'b0;
        repeat (49) begin
            @(negedge clk);
            if (err_timeout !== 1'b0 || busy !== 1'b1) early = 1'b1;
        end
        checks++;
        if (early) begin
            failures++;
            $display("FAIL tout_early: err_timeout=%b busy=%b before expiry",
                     err_timeout, busy);
        end
        @(negedge clk);
        checks++;
        if (err_timeout !== 1'b1 || busy !== 1'b0 || blk_data !== '0) begin
            failures++;
            $display("FAIL tout_fire: err=%b busy=%b blk=%h expected 1/0/0",
                     err_timeout, busy, blk_data);
        end
        acc   = '0;
        acc_n = 0;
        @(negedge clk);
        checks++;
        if (err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL tout_pulse: err_timeout=%b expected 0", err_timeout);
        end
        send_bytes(8'h80, 16);
        check_block("tout_repack");
        do_handshake("tout_hs");
        test_tx_stream(128'h0123456789ABCDEFFEDCBA9876543210, 1'b0);
    endtask

    task automatic test_expiry_race;
        send_bytes(8'hC0, 5);
        repeat (49) @(negedge clk);
        send_bytes(8'hC5, 1);
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL race: err_timeout=%b busy=%b expected 0/1",
                     err_timeout, busy);
        end
        repeat (3) @(negedge clk);
        send_bytes(8'hC6, 10);
        check_block("race_block");
        repeat (2) @(negedge clk);
        checks++;
        if (n_tout !== 1) begin
            failures++;
            $display("FAIL tout_total: got %0d expected 1", n_tout);
        end
        do_handshake("race_hs");
    endtask

    task automatic test_overrun;
        drive_rx(8'h55);
        checks++;
        if (err_overrun !== 1'b1 || res_ready !== 1'b1) begin
            failures++;
            $display("FAIL ovr_res: err_overrun=%b res_ready=%b expected 1/1",
                     err_overrun, res_ready);
        end
        test_tx_stream(128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, 1'b1);
        checks++;
        if (n_ovr !== 2) begin
            failures++;
            $display("FAIL ovr_total: got %0d expected 2", n_ovr);
        end
    endtask

    task automatic test_reset_mid;
        int txv0;
        bit ok;
        send_bytes(8'h20, 16);
        check_block("rst_block");
        do_handshake("rst_hs");
        res_data  = 128'h123456789ABCDEF00FEDCBA987654321;
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_pdvalid !== 1'b1 || tx_pdata !== 8'h12) begin
            failures++;
            $display("FAIL rst_pre: tx_pdvalid=%b tx_pdata=%h expected 1/12",
                     tx_pdvalid, tx_pdata);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx_pdvalid, blk_valid, res_ready, busy, err_timeout,
             err_overrun} !== 6'b0 || blk_data !== '0 || tx_pdata !== '0) begin
            failures++;
            $display("FAIL rst_mid: flags=%b blk=%h tx=%h expected 0",
                     {tx_pdvalid, blk_valid, res_ready, busy, err_timeout,
                      err_overrun}, blk_data, tx_pdata);
        end
        rst     = 1'b0;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        txv0 = n_txv;
        ok = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (tx_pdvalid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok || n_txv != txv0) begin
            failures++;
            $display("FAIL stray_done: tx_pdvalid=%b busy=%b pulses=%0d expected 0",
                     tx_pdvalid, busy, n_txv - txv0);
        end
    endtask

    initial begin
        rst        = 1'b1;
        rx_pdvalid = 1'b0;
        rx_pdata   = '0;
        tx_done    = 1'b0;
        blk_ready  = 1'b0;
        res_valid  = 1'b0;
        res_data   = '0;
        acc        = '0;
        acc_n      = 0;
        repeat (3) @(negedge clk);
        test_reset;
        test_block_pack;
        test_tx_stream(128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, 1'b0);
        test_timeout;
        test_expiry_race;
        test_overrun;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
